// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared types and helpers for the BCD up/down counter and its binary-to-BCD
// preload converter.
//   bcd_digit_t : one packed BCD digit (legal values 0..9)
//   BCD_MAX     : largest legal digit value
//   bcd_state_t : converter FSM states (IDLE, CONV)
//   bcd_add3    : double-dabble correction, adds 3 to any digit >= 5
// ----------------------------------------------------------------------------
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CONV = 1'b1
   } bcd_state_t;

   // A digit >= 5 would exceed 9 after the doubling shift, so pre-bias it by 3
   // to make the shift carry into the next digit instead.
   function automatic bcd_digit_t bcd_add3(input bcd_digit_t digit);
      bcd_digit_t res;
      if (digit >= 4'd5) begin
         res = digit + 4'd3;
      end else begin
         res = digit;
      end
      return res;
   endfunction

endpackage

// File: rtl/bcd_updown_counter_bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// bin2bcd_seq
// Iterative double-dabble converter: one add-3/shift step per clock, WIDTH
// steps per conversion. The scratch register is DIGITS digits wide; bits
// shifted out of the top are dropped, so the result is bin mod 10^DIGITS.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous reset, active low; aborts a running conversion
//   start_i  : begin a conversion of bin_i (honoured only in IDLE)
//   bin_i    : binary value to convert, WIDTH bits
//   busy_o   : high while a conversion is running
//   done_o   : high in the cycle whose closing edge performs the last step
//   bcd_o    : converted value; valid while done_o is high
// ----------------------------------------------------------------------------
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
)
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [WIDTH-1:0]      bin_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [4*DIGITS-1:0]   bcd_o
);

   localparam int              CW        = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH - 1);

   bcd_state_t              state_q, state_d;
   logic [WIDTH-1:0]        shift_q, shift_d;
   logic [4*DIGITS-1:0]     scratch_q, scratch_d;
   logic [4*DIGITS-1:0]     adj_s;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    last_s;

   // Add-3 correction applied to every scratch digit before the shift
   always_comb begin
      adj_s = scratch_q;
      for (int i = 0; i < DIGITS; i++) begin
         adj_s[4*i +: 4] = bcd_add3(scratch_q[4*i +: 4]);
      end
   end

   assign last_s = (state_q == CONV) && (cnt_q == LAST_STEP);

   // Converter next-state logic
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d   = CONV;
               shift_d   = bin_i;
               scratch_d = '0;
               cnt_d     = '0;
            end else begin
               state_d   = IDLE;
            end
         end
         CONV: begin
            // {scratch, shift} shifted left by one; top scratch bit is dropped
            scratch_d = {adj_s[4*DIGITS-2:0], shift_q[WIDTH-1]};
            shift_d   = shift_q << 1'b1;
            if (last_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               state_d = CONV;
               cnt_d   = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Converter state registers with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
      end
   end

   assign busy_o = (state_q == CONV);
   assign done_o = last_s;
   // The final step's shifted value is handed over on the same edge it forms
   assign bcd_o  = scratch_d;

endmodule

// File: rtl/bcd_updown_counter.sv
// ----------------------------------------------------------------------------
// bcd_updown_counter
// Multi-digit decimal up/down counter held natively in BCD. Binary preload
// values are converted by bin2bcd_seq over WIDTH cycles; the count register
// holds its old value until the conversion completes.
// Build option: BCD_SATURATE_EN -- when defined, counting saturates at
// all-9s (up) and 0 (down) and wrap_o pulses on every blocked step; when
// undefined, counting wraps modulo 10^DIGITS.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous reset, active low
//   en_i   : count enable, one step per cycle
//   up_i   : 1 = increment, 0 = decrement
//   ld_i   : request preload of v_i (wins over en_i, ignored while busy)
//   v_i    : binary preload value, WIDTH bits
//   bcd_o  : current count, digit 0 (units) in bcd_o[3:0]
//   busy_o : high while a preload conversion runs
//   wrap_o : one-cycle pulse after a decimal wrap (or blocked step)
// ----------------------------------------------------------------------------
module bcd_updown_counter
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
)
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic                  up_i,
   input  logic                  ld_i,
   input  logic [WIDTH-1:0]      v_i,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic                  busy_o,
   output logic                  wrap_o
);

   logic [4*DIGITS-1:0]   bcd_q, bcd_d;
   logic [4*DIGITS-1:0]   inc_s, dec_s, conv_s;
   logic                  wrap_q, wrap_d;
   logic                  carry_s, borrow_s;
   logic                  conv_busy_s, conv_done_s, start_s;
   logic                  step_s;

   assign start_s = ld_i && !conv_busy_s;
   assign step_s  = en_i && !ld_i && !conv_busy_s;

   bin2bcd_seq #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) u_conv (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_i_w()),
      .bin_i   (v_i),
      .busy_o  (conv_busy_s),
      .done_o  (conv_done_s),
      .bcd_o   (conv_s)
   );

   function automatic logic start_i_w();
      return start_s;
   endfunction

   // Ripple increment/decrement; final carry/borrow means all-9s / all-0s
   always_comb begin
      inc_s    = bcd_q;
      dec_s    = bcd_q;
      carry_s  = 1'b1;
      borrow_s = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry_s) begin
            if (bcd_q[4*i +: 4] == BCD_MAX) begin
               inc_s[4*i +: 4] = 4'd0;
            end else begin
               inc_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
               carry_s         = 1'b0;
            end
         end else begin
            inc_s[4*i +: 4] = bcd_q[4*i +: 4];
         end
         if (borrow_s) begin
            if (bcd_q[4*i +: 4] == 4'd0) begin
               dec_s[4*i +: 4] = BCD_MAX;
            end else begin
               dec_s[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
               borrow_s        = 1'b0;
            end
         end else begin
            dec_s[4*i +: 4] = bcd_q[4*i +: 4];
         end
      end
   end

   // Count register next value and wrap detection
   always_comb begin
      bcd_d  = bcd_q;
      wrap_d = 1'b0;
      if (conv_done_s) begin
         bcd_d = conv_s;
      end else if (step_s) begin
         if (up_i) begin
            if (carry_s) begin
               wrap_d = 1'b1;
`ifdef BCD_SATURATE_EN
               bcd_d  = bcd_q;
`else
               bcd_d  = inc_s;
`endif
            end else begin
               bcd_d  = inc_s;
            end
         end else begin
            if (borrow_s) begin
               wrap_d = 1'b1;
`ifdef BCD_SATURATE_EN
               bcd_d  = bcd_q;
`else
               bcd_d  = dec_s;
`endif
            end else begin
               bcd_d  = dec_s;
            end
         end
      end else begin
         bcd_d = bcd_q;
      end
   end

   // Count and wrap registers with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         bcd_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         bcd_q  <= bcd_d;
         wrap_q <= wrap_d;
      end
   end

   assign bcd_o  = bcd_q;
   assign busy_o = conv_busy_s;
   assign wrap_o = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// ----------------------------------------------------------------------------
// tb_bcd_updown_counter
// Self-checking bench: directed table, hand-written corner sequences and a
// random phase, all compared against an integer reference model.
// ----------------------------------------------------------------------------
module tb_bcd_updown_counter;

   localparam int W    = 8;
   localparam int MAXV = 999;

   logic        clk = 1'b0;
   logic        rst, en, up, ld;
   logic [7:0]  v;
   logic [11:0] bcd;
   logic        busy, wrap;

   logic        rst2, en2, up2, ld2;
   logic [7:0]  v2;
   logic [7:0]  bcd2;
   logic        busy2, wrap2;

   int n_checks = 0;
   int n_fail   = 0;

   int m_val  = 0;
   int m_busy = 0;
   int m_pend = 0;
   bit m_wrap = 1'b0;

   always #5 clk = ~clk;

   bcd_updown_counter #(.WIDTH(8), .DIGITS(3)) u_dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .ld_i(ld), .v_i(v),
      .bcd_o(bcd), .busy_o(busy), .wrap_o(wrap)
   );

   bcd_updown_counter #(.WIDTH(8), .DIGITS(2)) u_dut2 (
      .clk_i(clk), .rst_i(rst2), .en_i(en2), .up_i(up2), .ld_i(ld2), .v_i(v2),
      .bcd_o(bcd2), .busy_o(busy2), .wrap_o(wrap2)
   );

   typedef struct {
      bit          rst, en, up, ld;
      logic [7:0]  v;
      logic [11:0] exp_bcd;
      bit          exp_busy, exp_wrap;
   } vec_t;

   function automatic logic [11:0] to_bcd(input int x);
      return {4'(x / 100 % 10), 4'(x / 10 % 10), 4'(x % 10)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: decimal value as an integer, preload as a countdown timer
   task automatic model_step();
      if (!rst) begin
         m_val = 0; m_busy = 0; m_wrap = 1'b0;
      end else if (m_busy > 0) begin
         m_busy--;
         m_wrap = 1'b0;
         if (m_busy == 0) m_val = m_pend;
      end else if (ld) begin
         m_pend = int'(v) % (MAXV + 1);
         m_busy = W;
         m_wrap = 1'b0;
      end else if (en) begin
         if (up) begin
            if (m_val == MAXV) begin
               m_wrap = 1'b1;
`ifndef BCD_SATURATE_EN
               m_val  = 0;
`endif
            end else begin
               m_val++; m_wrap = 1'b0;
            end
         end else begin
            if (m_val == 0) begin
               m_wrap = 1'b1;
`ifndef BCD_SATURATE_EN
               m_val  = MAXV;
`endif
            end else begin
               m_val--; m_wrap = 1'b0;
            end
         end
      end else begin
         m_wrap = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("model_bcd", 32'(bcd), 32'(to_bcd(m_val)));
      chk("model_busy", 32'(busy), 32'(m_busy > 0));
      chk("model_wrap", 32'(wrap), 32'(m_wrap));
   endtask

   function automatic vec_t mk(bit r, bit e, bit u, bit l, logic [7:0] val,
                               logic [11:0] b, bit bz, bit wr);
      vec_t t;
      t.rst = r; t.en = e; t.up = u; t.ld = l; t.v = val;
      t.exp_bcd = b; t.exp_busy = bz; t.exp_wrap = wr;
      return t;
   endfunction

   vec_t tbl[$];
   int   nw, wrap_at, busy_cycles;

   initial begin
      rst = 1'b0; en = 1'b0; up = 1'b0; ld = 1'b0; v = 8'd0;
      rst2 = 1'b0; en2 = 1'b0; up2 = 1'b0; ld2 = 1'b0; v2 = 8'd0;

      // ---- directed table ----
      tbl.push_back(mk(0, 0, 0, 0, 8'd0,  12'h000, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 8'd0,  12'h001, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 8'd0,  12'h002, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 8'd0,  12'h001, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 8'd0,  12'h000, 0, 0));
`ifdef BCD_SATURATE_EN
      tbl.push_back(mk(1, 1, 0, 0, 8'd0,  12'h000, 0, 1));
      tbl.push_back(mk(1, 1, 0, 0, 8'd0,  12'h000, 0, 1));
`else
      tbl.push_back(mk(1, 1, 0, 0, 8'd0,  12'h999, 0, 1));
      tbl.push_back(mk(1, 1, 0, 0, 8'd0,  12'h998, 0, 0));
`endif
      tbl.push_back(mk(0, 1, 1, 0, 8'd0,  12'h000, 0, 0));
      tbl.push_back(mk(1, 1, 1, 1, 8'd42, 12'h000, 1, 0));
      for (int i = 0; i < 7; i++)
         tbl.push_back(mk(1, 1, 1, 0, 8'd0, 12'h000, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 8'd0,  12'h042, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 8'd0,  12'h043, 0, 0));
      tbl.push_back(mk(1, 0, 1, 0, 8'd0,  12'h043, 0, 0));

      foreach (tbl[k]) begin
         rst = tbl[k].rst; en = tbl[k].en; up = tbl[k].up;
         ld = tbl[k].ld; v = tbl[k].v;
         tick();
         chk("tbl_bcd",  32'(bcd),  32'(tbl[k].exp_bcd));
         chk("tbl_busy", 32'(busy), 32'(tbl[k].exp_busy));
         chk("tbl_wrap", 32'(wrap), 32'(tbl[k].exp_wrap));
      end

      // ---- 1000 up-steps from reset: exactly one wrap pulse ----
      rst = 1'b0; en = 1'b0; ld = 1'b0; tick();
      rst = 1'b1; en = 1'b1; up = 1'b1;
      nw = 0; wrap_at = -1;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (wrap) begin nw++; wrap_at = i; end
         if (i == 998) chk("up_at_999", 32'(bcd), 32'h999);
      end
      chk("up_wrap_count", 32'(nw), 32'd1);
      chk("up_wrap_cycle", 32'(wrap_at), 32'd999);
`ifdef BCD_SATURATE_EN
      chk("up_final", 32'(bcd), 32'h999);
      tick(); tick();
      chk("sat_hold_999", 32'(bcd), 32'h999);
      chk("sat_wrap_999", 32'(wrap), 32'd1);
`else
      chk("up_final", 32'(bcd), 32'h000);
`endif

      // ---- down from 000 ----
      rst = 1'b0; en = 1'b0; tick();
      rst = 1'b1; en = 1'b1; up = 1'b0; tick();
`ifdef BCD_SATURATE_EN
      chk("down_0_bcd", 32'(bcd), 32'h000);
`else
      chk("down_0_bcd", 32'(bcd), 32'h999);
`endif
      chk("down_0_wrap", 32'(wrap), 32'd1);
      tick();
`ifdef BCD_SATURATE_EN
      chk("down_next", 32'(bcd), 32'h000);
`else
      chk("down_next", 32'(bcd), 32'h998);
      chk("down_next_wrap", 32'(wrap), 32'd0);
`endif

      // ---- preload 255, ld/en pulsed during conversion ignored ----
      en = 1'b0; ld = 1'b1; v = 8'd255; tick();
      ld = 1'b0; busy_cycles = 1;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin ld = 1'b1; v = 8'd7; en = 1'b1; end
         else begin ld = 1'b0; en = 1'b0; end
         tick();
         if (busy) busy_cycles++;
      end
      chk("ld255_busy_cycles", 32'(busy_cycles), 32'd8);
      chk("ld255_bcd", 32'(bcd), 32'h255);
      chk("ld255_busy_end", 32'(busy), 32'd0);

      // ---- reset in the middle of a conversion ----
      ld = 1'b1; v = 8'd123; tick();
      ld = 1'b0; tick(); tick(); tick();
      rst = 1'b0; tick();
      chk("midrst_bcd", 32'(bcd), 32'h000);
      chk("midrst_busy", 32'(busy), 32'd0);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk("midrst_after", 32'(bcd), 32'h000);

      // ---- two-digit instance: load is taken mod 100 ----
      rst2 = 1'b1; ld2 = 1'b1; v2 = 8'd199;
      @(posedge clk); #1; ld2 = 1'b0;
      for (int i = 0; i < 8; i++) begin @(posedge clk); #1; end
      chk("d2_ld199", 32'(bcd2), 32'h99);
      chk("d2_busy", 32'(busy2), 32'd0);
      ld2 = 1'b1; v2 = 8'd37;
      @(posedge clk); #1; ld2 = 1'b0;
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
      rst2 = 1'b0;
      @(posedge clk); #1;
      chk("d2_midrst_bcd", 32'(bcd2), 32'h00);
      chk("d2_midrst_busy", 32'(busy2), 32'd0);
      rst2 = 1'b1;
      for (int i = 0; i < 8; i++) begin @(posedge clk); #1; end
      chk("d2_midrst_after", 32'(bcd2), 32'h00);

      // ---- random phase against the model ----
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 99) != 0);
         ld  = ($urandom_range(0, 19) == 0);
         en  = ($urandom_range(0, 3) != 0);
         up  = ($urandom_range(0, 1) == 1);
         v   = 8'($urandom);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
